adder_share_ctrl: RTL and testbench
===================================

Name: adder_share_ctrl

Overview:
- Shares one WIDTH-bit adder (sum = a + b + carry-in) between two requesters.
- Each requester submits multi-beat add operations, least-significant byte first; carry chains across beats, so two 8-bit lanes can do 16/24/32-bit adds.
- A burst holds the grant until its last beat. Arbitration between bursts is round-robin.
- Output is one registered result stage with a valid/ready handshake. The block sits between the user-logic requesters and the shared adder output pins.

Parameters:
- WIDTH, 8, operand and sum width per beat.

Ports:
- clk  input  1  system clock; one clock, all logic on the rising edge
- rst  input  1  reset is synchronous and active-high
- r0_valid  input  1  requester 0 beat valid
- r0_ready  output  1  requester 0 beat accepted this cycle when valid and ready are both high
- r0_a  input  WIDTH  requester 0 operand A
- r0_b  input  WIDTH  requester 0 operand B
- r0_last  input  1  requester 0 final beat of burst
- r1_valid, r1_ready, r1_a, r1_b, r1_last: same as the r0_* ports, for requester 1
- res_valid  output  1  result beat valid
- res_ready  input  1  downstream accepts result
- res_sum  output  WIDTH  beat sum
- res_cout  output  1  carry out of this beat
- res_id  output  1  requester index owning this beat
- res_last  output  1  echoes last of the accepted beat
- busy  output  1  high when state is BURST or res_valid is high

Behaviour:
- States are IDLE and BURST. Registers:
  - state
  - gnt (1b): current owner
  - ptr (1b): priority, 0 = r0 preferred
  - carry (1b)
  - output stage: res_*
- slot_free = !res_valid | res_ready. Beats are accepted only when slot_free.
- IDLE selection:
  - only r0_valid → pick 0; only r1_valid → pick 1
  - both → pick ptr
  - neither → no pick
- IDLE readys: ready of the picked requester = slot_free. The other ready = 0.
- BURST readys: ready of gnt = slot_free. The other ready = 0 regardless of its valid.
- On accept (valid & ready):
  - {cout, sum} = a + b + cin, computed at WIDTH+1 bits
  - cin = 0 for the first beat of a burst (accept in IDLE); cin = carry in BURST
  - output regs load sum, cout, id, last; res_valid becomes 1 on the next edge. Latency is 1 cycle.
  - if !last: state → BURST, gnt = id, carry = cout
  - if last: state → IDLE, carry = 0, ptr = ~id
- A single-beat burst (last on the first beat) goes IDLE → IDLE and still flips ptr.
- Result hold: while res_valid & !res_ready, all res_* are held stable and no beat is accepted. Back-to-back accept with res_ready = 1 sustains 1 beat/cycle.
- res_valid clears on res_ready when there is no new accept that cycle.
- Wrap-around:
  - 0xFF + 0x01 + 0 → sum 0x00, cout 1
  - 0xFF + 0xFF + 1 → sum 0xFF, cout 1
- Owner gap: if the owner drops valid mid-burst, the block waits in BURST indefinitely. The grant and carry are held and the other requester stays blocked.
- Simultaneous last-accept and a new request from the other side: the new request is considered on the following cycle (IDLE). No same-cycle handoff.
- Reset, including mid-burst:
  - state = IDLE, gnt = 0, ptr = 0, carry = 0
  - res_valid = 0, res_sum = 0, res_cout = 0, res_id = 0, res_last = 0
  - r0_ready = r1_ready = 0 and busy = 0 while rst is high
  - a partial burst is abandoned; no result is emitted for it.

Decomposition:
- Package adder_ctrl_pkg:
  - WIDTH default constant
  - state enum {ST_IDLE, ST_BURST}
  - requester index constants REQ0 = 0, REQ1 = 1
- One natural sub-module, rr_arb2: a 2-way round-robin pick.
  - inputs: two requests, ptr
  - outputs: pick, any
  - purely combinational
- FSM, carry chain and output register live in adder_share_ctrl.

Test Plan:
1. Reset, then r0 single beat a=0x12 b=0x34 last=1 with res_ready=1 → next cycle res_valid=1, res_sum=0x46, res_cout=0, res_id=0, res_last=1; ptr becomes 1.
2. r0 2-beat 16-bit add 0x01FF+0x0001: beats (0xFF,0x01,last=0), (0x01,0x00,last=1) → results 0x00/cout1, then 0x02/cout0; r1_valid held high throughout keeps r1_ready=0 until r0's last beat is accepted.
3. Both valid in IDLE after reset, single-beat bursts each → grants alternate r0, r1, r0, r1; res_id sequence 0,1,0,1.
4. Backpressure: res_ready=0 for 3 cycles with result 0xAA pending → res_* stable, r0_ready=r1_ready=0; on res_ready=1 the next beat is accepted that cycle.
5. Mid-burst reset: r1 first beat 0xFF+0x01 (last=0) accepted, then rst=1 → all outputs 0, busy=0; next r1 beat 0x00+0x00 last=1 → sum 0x00, cout 0 (no stale carry).
6. Owner gap: r0 burst beat1 (0x80,0x80,last=0), r0_valid low for 5 cycles while r1_valid=1 → r1_ready stays 0, busy=1; r0 beat2 (0x00,0x00,last=1) → sum 0x01.

Source files
------------

// File: rtl/adder_ctrl_pkg.sv
// Shared definitions for the shared-adder controller.
//   WIDTH_DEF : default operand/sum width per beat
//   state_e   : controller state (idle between bursts, or inside a burst)
//   REQ0/REQ1 : requester indices as carried on res_id and the grant register
package adder_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 8;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational.
//   req0, req1 : request lines
//   ptr        : priority pointer, REQ0 prefers requester 0 when both request
//   pick       : chosen requester index (REQ0 when nothing requests)
//   any        : at least one request present
module rr_arb2
  import adder_ctrl_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic pick,
  output logic any
);

  always_comb begin
    any  = req0 | req1;
    pick = REQ0;
    if (req0 && req1) begin
      pick = ptr;
    end else if (req1) begin
      pick = REQ1;
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one WIDTH-bit adder between two requesters issuing multi-beat adds.
// Beats are LSB-first and the carry chains across beats of a burst. A burst keeps
// its grant until the last beat; bursts are arbitrated round-robin. Results leave
// through a single registered valid/ready stage.
//   clk, rst                : clock, synchronous active-high reset
//   r0_* / r1_*             : requester beat channels (valid/ready, a, b, last)
//   res_valid / res_ready   : result handshake
//   res_sum, res_cout       : beat sum and carry out
//   res_id, res_last        : owning requester and its last flag
//   busy                    : inside a burst or holding a result
module adder_share_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic             r0_last,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic             r1_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id,
  output logic             res_last,
  output logic             busy
);

  state_e state_q, state_d;

  logic             gnt_q;
  logic             ptr_q;
  logic             carry_q;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_sum_q;
  logic             res_cout_q;
  logic             res_id_q;
  logic             res_last_q;

  logic             slot_free;
  logic             arb_pick;
  logic             arb_any;
  logic             sel;
  logic             sel_last;
  logic             accept;
  logic             cin;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH:0]   sum_full;

  rr_arb2 u_arb (
    .req0 (r0_valid),
    .req1 (r1_valid),
    .ptr  (ptr_q),
    .pick (arb_pick),
    .any  (arb_any)
  );

  // A beat may enter only when the result slot is empty or draining this cycle.
  assign slot_free = !res_valid_q || res_ready;

  // Owner of the adder this cycle: the burst holder, otherwise the arbiter's pick.
  always_comb begin
    sel      = (state_q == ST_BURST) ? gnt_q : arb_pick;
    sel_a    = (sel == REQ1) ? r1_a    : r0_a;
    sel_b    = (sel == REQ1) ? r1_b    : r0_b;
    sel_last = (sel == REQ1) ? r1_last : r0_last;
    cin      = (state_q == ST_BURST) ? carry_q : 1'b0;
    sum_full = {1'b0, sel_a} + {1'b0, sel_b} + {{WIDTH{1'b0}}, cin};
    accept   = (sel == REQ1) ? (r1_valid && r1_ready) : (r0_valid && r0_ready);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: each accepted beat either closes the burst or keeps it open.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = sel_last ? ST_IDLE : ST_BURST;
    end
  end

  // Outputs of the FSM: readys and busy.
  always_comb begin
    r0_ready = 1'b0;
    r1_ready = 1'b0;
    busy     = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          r0_ready = slot_free && arb_any && (arb_pick == REQ0);
          r1_ready = slot_free && arb_any && (arb_pick == REQ1);
        end
        ST_BURST: begin
          // Non-owner stays blocked even if the owner has gone quiet.
          r0_ready = slot_free && (gnt_q == REQ0);
          r1_ready = slot_free && (gnt_q == REQ1);
        end
        default: ;
      endcase
      busy = (state_q == ST_BURST) || res_valid_q;
    end
  end

  // Grant, priority, carry and the result stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q       <= REQ0;
      ptr_q       <= REQ0;
      carry_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
      res_id_q    <= REQ0;
      res_last_q  <= 1'b0;
    end else if (accept) begin
      res_valid_q <= 1'b1;
      res_sum_q   <= sum_full[WIDTH-1:0];
      res_cout_q  <= sum_full[WIDTH];
      res_id_q    <= sel;
      res_last_q  <= sel_last;
      if (sel_last) begin
        carry_q <= 1'b0;
        ptr_q   <= ~sel;
      end else begin
        gnt_q   <= sel;
        carry_q <= sum_full[WIDTH];
      end
    end else if (res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_id    = res_id_q;
  assign res_last  = res_last_q;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a model.
module tb_adder_share_ctrl;

  logic       clk;
  logic       rst;
  logic       r0_valid, r0_ready, r0_last;
  logic [7:0] r0_a, r0_b;
  logic       r1_valid, r1_ready, r1_last;
  logic [7:0] r1_a, r1_b;
  logic       res_valid, res_ready;
  logic [7:0] res_sum;
  logic       res_cout, res_id, res_last, busy;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  adder_share_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_valid  (r0_valid),
    .r0_ready  (r0_ready),
    .r0_a      (r0_a),
    .r0_b      (r0_b),
    .r0_last   (r0_last),
    .r1_valid  (r1_valid),
    .r1_ready  (r1_ready),
    .r1_a      (r1_a),
    .r1_b      (r1_b),
    .r1_last   (r1_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_id    (res_id),
    .res_last  (res_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // owner: requester holding an open burst, -1 when between bursts.
  int       m_owner = -1;
  int       m_ptr   = 0;
  int       m_carry = 0;
  bit       m_rv    = 0;
  int       m_sum   = 0;
  int       m_cout  = 0;
  int       m_id    = 0;
  int       m_last  = 0;

  // Which requester is allowed to hand in a beat right now (-1: nobody).
  function automatic int who_ready();
    if (rst) return -1;
    if (m_rv && !res_ready) return -1;
    if (m_owner >= 0) return m_owner;
    if (r0_valid && r1_valid) return m_ptr;
    if (r0_valid) return 0;
    if (r1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w, a, b, l, total;
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_carry = 0;
      m_rv = 0; m_sum = 0; m_cout = 0; m_id = 0; m_last = 0;
    end else begin
      w = who_ready();
      if (w == 0 && !r0_valid) w = -1;
      if (w == 1 && !r1_valid) w = -1;
      if (w >= 0) begin
        a = (w == 0) ? int'(r0_a) : int'(r1_a);
        b = (w == 0) ? int'(r0_b) : int'(r1_b);
        l = (w == 0) ? int'(r0_last) : int'(r1_last);
        total  = a + b + ((m_owner >= 0) ? m_carry : 0);
        m_sum  = total % 256;
        m_cout = total / 256;
        m_id   = w;
        m_last = l;
        m_rv   = 1;
        if (l != 0) begin
          m_owner = -1; m_carry = 0; m_ptr = 1 - w;
        end else begin
          m_owner = w; m_carry = m_cout;
        end
      end else if (res_ready) begin
        m_rv = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int w;
    if (chk_en) begin
      w = who_ready();
      check("r0_ready", 32'(r0_ready), 32'(w == 0));
      check("r1_ready", 32'(r1_ready), 32'(w == 1));
      check("busy", 32'(busy), 32'(!rst && (m_owner >= 0 || m_rv)));
      check("res_valid", 32'(res_valid), 32'(m_rv));
      check("res_sum", 32'(res_sum), 32'(m_sum));
      check("res_cout", 32'(res_cout), 32'(m_cout));
      check("res_id", 32'(res_id), 32'(m_id));
      check("res_last", 32'(res_last), 32'(m_last));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_r0(input logic v, input logic [7:0] a, input logic [7:0] b, input logic l);
    r0_valid = v; r0_a = a; r0_b = b; r0_last = l;
  endtask

  task automatic set_r1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic l);
    r1_valid = v; r1_a = a; r1_b = b; r1_last = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_r0(0, 8'h00, 8'h00, 0);
    set_r1(0, 8'h00, 8'h00, 0);
    res_ready = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    res_ready = 1'b1;
    set_r0(0, 8'h00, 8'h00, 0);
    set_r1(0, 8'h00, 8'h00, 0);
    cyc();
    cyc();
    rst = 1'b0;
    chk_en = 1;

    // 1: single beat from r0, then ptr must favour r1.
    set_r0(1, 8'h12, 8'h34, 1);
    #1 check("t1_r0_ready", 32'(r0_ready), 32'd1);
    cyc();
    set_r0(1, 8'h00, 8'h00, 1);
    set_r1(1, 8'h00, 8'h00, 1);
    #1;
    check("t1_valid", 32'(res_valid), 32'd1);
    check("t1_sum", 32'(res_sum), 32'h46);
    check("t1_cout", 32'(res_cout), 32'd0);
    check("t1_id", 32'(res_id), 32'd0);
    check("t1_last", 32'(res_last), 32'd1);
    check("t1_model_sum", 32'(m_sum), 32'h46);
    check("t1_ptr_r1", 32'(r1_ready), 32'd1);
    check("t1_ptr_r0", 32'(r0_ready), 32'd0);

    // 2: 16-bit add 0x01FF + 0x0001 from r0 while r1 waits.
    do_reset();
    set_r0(1, 8'hFF, 8'h01, 0);
    set_r1(1, 8'h05, 8'h05, 1);
    #1 check("t2_b1_r1_blocked", 32'(r1_ready), 32'd0);
    cyc();
    set_r0(1, 8'h01, 8'h00, 1);
    #1;
    check("t2_b1_sum", 32'(res_sum), 32'h00);
    check("t2_b1_cout", 32'(res_cout), 32'd1);
    check("t2_b1_model_cout", 32'(m_cout), 32'd1);
    check("t2_b2_r1_blocked", 32'(r1_ready), 32'd0);
    cyc();
    set_r0(0, 8'h00, 8'h00, 0);
    #1;
    check("t2_b2_sum", 32'(res_sum), 32'h02);
    check("t2_b2_cout", 32'(res_cout), 32'd0);
    check("t2_r1_now_ready", 32'(r1_ready), 32'd1);
    cyc();
    set_r1(0, 8'h00, 8'h00, 0);

    // 3: both valid with single-beat bursts alternate 0,1,0,1.
    do_reset();
    set_r0(1, 8'h01, 8'h00, 1);
    set_r1(1, 8'h02, 8'h00, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      check("t3_id", 32'(res_id), 32'(i % 2));
      check("t3_sum", 32'(res_sum), (i % 2 == 1) ? 32'h2 : 32'h1);
    end

    // 4: backpressure holds result 0xAA and blocks both requesters.
    do_reset();
    res_ready = 1'b0;
    set_r0(1, 8'hAA, 8'h00, 1);
    cyc();
    set_r0(1, 8'h11, 8'h00, 1);
    set_r1(1, 8'h22, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_hold_valid", 32'(res_valid), 32'd1);
      check("t4_hold_sum", 32'(res_sum), 32'hAA);
      check("t4_r0_blocked", 32'(r0_ready), 32'd0);
      check("t4_r1_blocked", 32'(r1_ready), 32'd0);
      cyc();
    end
    res_ready = 1'b1;
    #1 check("t4_release_r1", 32'(r1_ready), 32'd1);
    cyc();
    set_r0(0, 8'h00, 8'h00, 0);
    set_r1(0, 8'h00, 8'h00, 0);
    #1;
    check("t4_next_sum", 32'(res_sum), 32'h22);
    check("t4_next_id", 32'(res_id), 32'd1);

    // 5: reset mid-burst drops the partial burst and its carry.
    do_reset();
    set_r1(1, 8'hFF, 8'h01, 0);
    cyc();
    rst = 1'b1;
    set_r1(0, 8'h00, 8'h00, 0);
    #1;
    check("t5_rst_r0_ready", 32'(r0_ready), 32'd0);
    check("t5_rst_r1_ready", 32'(r1_ready), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    cyc();
    #1;
    check("t5_valid0", 32'(res_valid), 32'd0);
    check("t5_sum0", 32'(res_sum), 32'd0);
    check("t5_cout0", 32'(res_cout), 32'd0);
    check("t5_last0", 32'(res_last), 32'd0);
    rst = 1'b0;
    set_r1(1, 8'h00, 8'h00, 1);
    #1 check("t5_r1_ready", 32'(r1_ready), 32'd1);
    cyc();
    set_r1(0, 8'h00, 8'h00, 0);
    #1;
    check("t5_sum", 32'(res_sum), 32'h00);
    check("t5_cout", 32'(res_cout), 32'd0);
    check("t5_id", 32'(res_id), 32'd1);

    // 6: owner gap keeps grant and carry.
    do_reset();
    set_r0(1, 8'h80, 8'h80, 0);
    cyc();
    set_r0(0, 8'h00, 8'h00, 0);
    set_r1(1, 8'h33, 8'h33, 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t6_r1_blocked", 32'(r1_ready), 32'd0);
      check("t6_busy", 32'(busy), 32'd1);
      cyc();
    end
    set_r0(1, 8'h00, 8'h00, 1);
    #1 check("t6_r0_ready", 32'(r0_ready), 32'd1);
    cyc();
    set_r0(0, 8'h00, 8'h00, 0);
    set_r1(0, 8'h00, 8'h00, 0);
    #1;
    check("t6_sum", 32'(res_sum), 32'h01);
    check("t6_cout", 32'(res_cout), 32'd0);
    check("t6_last", 32'(res_last), 32'd1);

    // Randomized traffic, occasional resets, corner operands.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 249) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
      set_r0($urandom_range(0, 3) != 0,
             ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
             ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
             $urandom_range(0, 2) == 0);
      set_r1($urandom_range(0, 3) != 0,
             ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
             ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
             $urandom_range(0, 2) == 0);
      cyc();
    end
    rst = 1'b0;
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
